// File: rtl/mat_cache_reader_if.sv
// Read-type package and bundle for the matrix cache read sequencer.
// Latency: none (wires only).
// Backpressure: carries cmd valid/ready and out valid/ready.
package mat_cache_reader_pkg;
    typedef enum logic [1:0] {
        MC_DIAG = 2'd0,
        MC_ROW  = 2'd1,
        MC_COL  = 2'd2
    } MatCacheReadType_t;
endpackage

interface mat_cache_reader_if #(
    parameter int WIDTH      = 128,
    parameter int CACHE_SIZE = 4
);
    localparam int WIDTH_ADDR_SIZE = 1 + $clog2(WIDTH);
    localparam int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE);

    // command channel
    logic                                   cmd_valid;
    logic                                   cmd_ready;
    mat_cache_reader_pkg::MatCacheReadType_t cmd_type;
    logic [CACHE_ADDR_SIZE-1:0]             cmd_addr1;
    logic [CACHE_ADDR_SIZE-1:0]             cmd_addr2;
    logic [WIDTH_ADDR_SIZE-1:0]             cmd_start;
    logic [WIDTH_ADDR_SIZE-1:0]             cmd_count;

    // cache read port; each element is an IEEE-754 single-precision word
    logic                                   cache_read_enable;
    mat_cache_reader_pkg::MatCacheReadType_t cache_read_type;
    logic [CACHE_ADDR_SIZE-1:0]             cache_read_addr1;
    logic [CACHE_ADDR_SIZE-1:0]             cache_read_addr2;
    logic [WIDTH_ADDR_SIZE-1:0]             cache_read_param;
    logic [WIDTH-1:0][31:0]                 cache_data;

    // vector stream to the consumer
    logic                                   out_valid;
    logic                                   out_ready;
    logic [WIDTH-1:0][31:0]                 out_data;
    logic [WIDTH_ADDR_SIZE-1:0]             out_index;
    logic                                   out_last;

    // status
    logic                                   busy;
    logic                                   done;

    modport slave (
        input  cmd_valid, cmd_type, cmd_addr1, cmd_addr2, cmd_start, cmd_count,
        output cmd_ready,
        output cache_read_enable, cache_read_type, cache_read_addr1,
               cache_read_addr2, cache_read_param,
        input  cache_data,
        output out_valid, out_data, out_index, out_last,
        input  out_ready,
        output busy, done
    );

    modport master (
        output cmd_valid, cmd_type, cmd_addr1, cmd_addr2, cmd_start, cmd_count,
        input  cmd_ready,
        input  cache_read_enable, cache_read_type, cache_read_addr1,
               cache_read_addr2, cache_read_param,
        output cache_data,
        input  out_valid, out_data, out_index, out_last,
        output out_ready,
        input  busy, done
    );
endinterface

// File: rtl/mat_cache_reader.sv
// Command-driven matrix cache read sequencer: sweeps params, streams captured vectors.
// Latency: command accept at cycle N -> first out_valid at N+2, then 1 vector/cycle.
// Backpressure: out_ready low holds the output register and stalls the param sweep.
module mat_cache_reader
    import mat_cache_reader_pkg::*;
#(
    parameter int WIDTH      = 128,
    parameter int CACHE_SIZE = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    mat_cache_reader_if.slave bus
);
    localparam int WAS = 1 + $clog2(WIDTH);
    localparam int CAS = $clog2(CACHE_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t                 state;
    MatCacheReadType_t      type_q;
    logic [CAS-1:0]         addr1_q;
    logic [CAS-1:0]         addr2_q;
    logic [WAS-1:0]         param_q;
    logic [WAS-1:0]         remaining_q;
    logic [WAS-1:0]         index_q;
    logic [WIDTH-1:0][31:0] data_q;
    logic                   valid_q;
    logic                   last_q;
    logic                   done_q;
    logic                   capture;

    // A new vector can be taken whenever the output slot is empty or being
    // drained this cycle, so a handshake in STREAM always coincides with a
    // capture and no beat is dropped or repeated.
    assign capture = (state == ST_STREAM) && (!valid_q || bus.out_ready);

    assign bus.cmd_ready         = (state == ST_IDLE);
    assign bus.busy              = (state != ST_IDLE);
    assign bus.done              = done_q;
    assign bus.cache_read_enable = capture;
    assign bus.cache_read_type   = type_q;
    assign bus.cache_read_addr1  = addr1_q;
    assign bus.cache_read_addr2  = addr2_q;
    assign bus.cache_read_param  = param_q;
    assign bus.out_valid         = valid_q;
    assign bus.out_data          = data_q;
    assign bus.out_index         = index_q;
    assign bus.out_last          = last_q;

    // Sequencer: accept a command, sweep params with wrap, drain the final beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            type_q      <= MC_ROW;
            addr1_q     <= '0;
            addr2_q     <= '0;
            param_q     <= '0;
            remaining_q <= '0;
            index_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        type_q      <= bus.cmd_type;
                        addr1_q     <= bus.cmd_addr1;
                        addr2_q     <= bus.cmd_addr2;
                        param_q     <= bus.cmd_start;
                        remaining_q <= bus.cmd_count;
                        if (bus.cmd_count == '0) begin
                            // empty command completes without streaming
                            done_q <= 1'b1;
                        end else begin
                            state <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (capture) begin
                        data_q      <= bus.cache_data;
                        index_q     <= param_q;
                        valid_q     <= 1'b1;
                        last_q      <= (remaining_q == WAS'(1));
                        param_q     <= (param_q == WAS'(WIDTH - 1)) ? '0 : param_q + WAS'(1);
                        remaining_q <= remaining_q - WAS'(1);
                        if (remaining_q == WAS'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (valid_q && bus.out_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mat_cache_reader.sv
// Randomized bench for mat_cache_reader with a queue-based reference model.
// Latency: checks accept-to-first-beat of 2 cycles and done one cycle after the last beat.
// Backpressure: drives out_ready always-high, held-low, or random.
module tb_mat_cache_reader;
    import mat_cache_reader_pkg::*;

    localparam int W   = 4;
    localparam int CS  = 4;
    localparam int WAS = 3;

    typedef logic [W-1:0][31:0] vec_t;
    typedef struct {
        vec_t           data;
        logic [WAS-1:0] index;
        logic           last;
    } beat_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mat_cache_reader_if #(.WIDTH(W), .CACHE_SIZE(CS)) bus ();

    mat_cache_reader #(.WIDTH(W), .CACHE_SIZE(CS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- cache contents and combinational read port ----------------
    logic [31:0] mem [CS][W][W];

    // Reference view of a cache read: row p, column p, or diagonal p where the
    // wrapped part of each diagonal comes from the second block.
    function automatic vec_t ref_vec(input int t, input int a1, input int a2, input int p);
        vec_t v;
        int   c;
        v = '0;
        for (int j = 0; j < W; j++) begin
            c = j + p;
            if (t == int'(MC_ROW))      v[j] = mem[a1][p][j];
            else if (t == int'(MC_COL)) v[j] = mem[a1][j][p];
            else if (c < W)             v[j] = mem[a1][j][c];
            else                        v[j] = mem[a2][j][c - W];
        end
        return v;
    endfunction

    int cp, cj;
    always_comb begin
        bus.cache_data = '0;
        cp = int'(bus.cache_read_param) % W;
        for (int j = 0; j < W; j++) begin
            cj = j + cp;
            if (bus.cache_read_type == MC_ROW)
                bus.cache_data[j] = mem[int'(bus.cache_read_addr1)][cp][j];
            else if (bus.cache_read_type == MC_COL)
                bus.cache_data[j] = mem[int'(bus.cache_read_addr1)][j][cp];
            else if (cj < W)
                bus.cache_data[j] = mem[int'(bus.cache_read_addr1)][j][cj];
            else
                bus.cache_data[j] = mem[int'(bus.cache_read_addr2)][j][cj - W];
        end
    end

    task automatic randomize_mem();
        for (int b = 0; b < CS; b++)
            for (int r = 0; r < W; r++)
                for (int c = 0; c < W; c++)
                    mem[b][r][c] = $urandom;
    endtask

    // ---------------- out_ready driver ----------------
    int ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
    always @(posedge clock) begin
        #2;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- reference model / scoreboard ----------------
    beat_t          exp_q[$];
    beat_t          b;
    bit             model_busy = 0;
    bit             done_pend  = 0;
    bit             lat_pend   = 0;
    bit             prev_stall = 0;
    bit             hs, acc, last_hs;
    int             acc_cyc    = 0;
    vec_t           prev_data;
    logic [WAS-1:0] prev_index;

    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            model_busy = 0;
            done_pend  = 0;
            lat_pend   = 0;
            prev_stall = 0;
        end else begin
            chk("done", bus.done, done_pend);
            chk("busy", bus.busy, model_busy);
            chk("cmd_ready", bus.cmd_ready, !model_busy);
            if (!model_busy) chk("idle_valid", bus.out_valid, 1'b0);
            if (prev_stall) begin
                chk("stall_valid", bus.out_valid, 1'b1);
                chk("stall_data", bus.out_data, prev_data);
                chk("stall_index", bus.out_index, prev_index);
            end
            if (lat_pend && bus.out_valid) begin
                chk("latency", cyc - acc_cyc, 2);
                lat_pend = 0;
            end
            hs      = bus.out_valid && bus.out_ready;
            last_hs = 0;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", bus.out_valid, 1'b0);
                end else begin
                    b = exp_q.pop_front();
                    chk("data", bus.out_data, b.data);
                    chk("index", bus.out_index, b.index);
                    chk("last", bus.out_last, b.last);
                    last_hs = b.last;
                end
            end
            acc       = bus.cmd_valid && bus.cmd_ready;
            done_pend = last_hs || (acc && bus.cmd_count == '0);
            if (last_hs) model_busy = 0;
            if (acc) begin
                for (int k = 0; k < int'(bus.cmd_count); k++) begin
                    b.index = WAS'((int'(bus.cmd_start) + k) % W);
                    b.data  = ref_vec(int'(bus.cmd_type), int'(bus.cmd_addr1),
                                      int'(bus.cmd_addr2), int'(b.index));
                    b.last  = (k == int'(bus.cmd_count) - 1);
                    exp_q.push_back(b);
                end
                if (bus.cmd_count != '0) begin
                    model_busy = 1;
                    lat_pend   = 1;
                    acc_cyc    = cyc;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_index = bus.out_index;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_cmd(input int t, input int a1, input int a2, input int st, input int cnt);
        bit ok;
        ok = 0;
        @(posedge clock); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = MatCacheReadType_t'(t);
        bus.cmd_addr1 = 2'(a1);
        bus.cmd_addr2 = 2'(a2);
        bus.cmd_start = WAS'(st);
        bus.cmd_count = WAS'(cnt);
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clock);
            ok = bus.cmd_ready;
        end
        if (!ok) chk("accept_timeout", bus.cmd_ready, 1'b1);
        @(posedge clock); #1;
        // scramble the fields so the DUT must rely on its latched copies
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = MatCacheReadType_t'($urandom_range(0, 2));
        bus.cmd_addr1 = 2'($urandom);
        bus.cmd_addr2 = 2'($urandom);
        bus.cmd_start = WAS'($urandom_range(0, W - 1));
        bus.cmd_count = WAS'($urandom_range(0, W));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge clock); #1;
            ok = !model_busy && (exp_q.size() == 0);
        end
        if (!ok) chk("idle_timeout", model_busy, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = MC_ROW;
        bus.cmd_addr1 = '0;
        bus.cmd_addr2 = '0;
        bus.cmd_start = '0;
        bus.cmd_count = '0;
        randomize_mem();

        // reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_ready", bus.cmd_ready, 1'b1);
        chk("rst_enable", bus.cache_read_enable, 1'b0);
        chk("rst_data", bus.out_data, '0);
        chk("rst_index", bus.out_index, '0);
        chk("rst_param", bus.cache_read_param, '0);
        chk("rst_type", bus.cache_read_type, MC_ROW);
        chk("rst_last", bus.out_last, 1'b0);
        reset_n = 1'b1;

        // row sweep with a free-running consumer
        send_cmd(int'(MC_ROW), 2, 0, 1, 3);
        wait_idle();

        // same command with the consumer stalled for four cycles
        send_cmd(int'(MC_ROW), 2, 0, 1, 3);
        ready_mode = 1;
        @(negedge clock);
        repeat (4) begin
            @(negedge clock);
            chk("hold_param", bus.cache_read_param, 3'd2);
            chk("hold_enable", bus.cache_read_enable, 1'b0);
            chk("hold_index", bus.out_index, 3'd1);
            chk("hold_valid", bus.out_valid, 1'b1);
        end
        @(posedge clock); #1;
        ready_mode = 0;
        wait_idle();

        // diagonal read wrapping past WIDTH-1
        randomize_mem();
        send_cmd(int'(MC_DIAG), 0, 1, 3, 3);
        wait_idle();

        // empty command
        send_cmd(int'(MC_ROW), 1, 0, 2, 0);
        wait_idle();

        // reset during the second beat, then a fresh command
        randomize_mem();
        send_cmd(int'(MC_ROW), 3, 0, 0, 4);
        @(posedge clock); #1;
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 1'b0);
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_data", bus.out_data, '0);
        chk("arst_enable", bus.cache_read_enable, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        send_cmd(int'(MC_ROW), 1, 0, 2, 3);
        wait_idle();

        // second command offered while the first still streams
        send_cmd(int'(MC_COL), 1, 0, 0, 4);
        send_cmd(int'(MC_ROW), 2, 0, 3, 2);
        wait_idle();

        // randomized commands, consumer and back-to-back issue
        for (int n = 0; n < 60; n++) begin
            ready_mode = ($urandom_range(0, 2) == 0) ? 0 : 2;
            if ($urandom_range(0, 2) != 0) begin
                wait_idle();
                randomize_mem();
            end
            send_cmd($urandom_range(0, 2), $urandom_range(0, CS - 1), $urandom_range(0, CS - 1),
                     $urandom_range(0, W - 1), $urandom_range(0, W));
        end
        ready_mode = 0;
        wait_idle();
        repeat (3) @(posedge clock);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
